// File: rtl/timer_bar_renderer.sv
// ---------------------------------------------------------------------------
// timer_bar_renderer
//
// Overlays a horizontal countdown bar on the VGA pixel stream. The game
// timer's elapsed value is sampled once per frame so the bar never tears.
// The bar shrinks as time elapses and changes colour green/yellow/red.
// It flashes white for a number of frames after a time penalty makes it
// jump. It blinks after a timeout and then settles into an empty frame.
//
// Ports
//   clk            pixel clock
//   reset          synchronous, active-high
//   x_pixel        current scan x (10 bit)
//   y_pixel        current scan y (10 bit)
//   display_en     active-video qualifier for the current pixel
//   frame_start    one-cycle pulse on the first cycle of each frame
//   pixel_timer    elapsed game time, 0..BAR_W-1 in normal play
//   start_trigger  game (re)start pulse
//   end_trigger    timeout pulse
//   rgb_in         background pixel, 4:4:4
//   rgb_out        composited pixel, 2 cycles after the inputs
//   bar_hit        pixel lies inside the bar frame, aligned with rgb_out
// ---------------------------------------------------------------------------
module timer_bar_renderer #(
    parameter int unsigned BAR_X0        = 220,
    parameter int unsigned BAR_Y0        = 20,
    parameter int unsigned BAR_W         = 200,
    parameter int unsigned BAR_H         = 16,
    parameter int unsigned FLASH_FRAMES  = 15,
    parameter int unsigned BLINK_FRAMES  = 30,
    parameter int unsigned BLINK_TOGGLES = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x_pixel,
    input  logic [9:0]  y_pixel,
    input  logic        display_en,
    input  logic        frame_start,
    input  logic [9:0]  pixel_timer,
    input  logic        start_trigger,
    input  logic        end_trigger,
    input  logic [11:0] rgb_in,
    output logic [11:0] rgb_out,
    output logic        bar_hit
);

    localparam int unsigned FL_W  = $clog2(FLASH_FRAMES + 1);
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned TOG_W = $clog2(BLINK_TOGGLES + 1);

    // Region bounds; the right and bottom ends are exclusive.
    localparam logic [9:0] X_FIRST = 10'(BAR_X0);
    localparam logic [9:0] X_END   = 10'(BAR_X0 + BAR_W);
    localparam logic [9:0] X_LAST  = 10'(BAR_X0 + BAR_W - 1);
    localparam logic [9:0] Y_FIRST = 10'(BAR_Y0);
    localparam logic [9:0] Y_END   = 10'(BAR_Y0 + BAR_H);
    localparam logic [9:0] Y_LAST  = 10'(BAR_Y0 + BAR_H - 1);
    localparam logic [9:0] W_10    = 10'(BAR_W);

    localparam logic [FL_W-1:0]  FLASH_LOAD = FL_W'(FLASH_FRAMES);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [TOG_W-1:0] TOG_LAST   = TOG_W'(BLINK_TOGGLES - 1);

    localparam logic [11:0] COL_WHITE  = 12'hFFF;
    localparam logic [11:0] COL_EMPTY  = 12'h222;
    localparam logic [11:0] COL_GREEN  = 12'h0F0;
    localparam logic [11:0] COL_YELLOW = 12'hFF0;
    localparam logic [11:0] COL_RED    = 12'hF00;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BLINK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Fill colour from the remaining width; a pending flash overrides it.
    function automatic logic [11:0] fill_colour(input logic [9:0] rem, input logic flash);
        logic [11:0] col;
        if (flash) begin
            col = COL_WHITE;
        end else if (rem > 10'd100) begin
            col = COL_GREEN;
        end else if (rem >= 10'd40) begin
            col = COL_YELLOW;
        end else begin
            col = COL_RED;
        end
        return col;
    endfunction

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [9:0]         t_cur_q, t_prev_q;
    logic               pen_chk_q;
    logic [FL_W-1:0]    flash_q, flash_d;
    logic [FRM_W-1:0]   blink_frm_q, blink_frm_d;
    logic [TOG_W-1:0]   blink_tog_q, blink_tog_d;
    logic               penalty;
    logic               bar_hide;
    logic               fill_allow;

    // Frame-synchronous timer sample. pen_chk_q marks the cycle after a
    // frame_start, when t_cur/t_prev both hold the fresh pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            t_cur_q   <= 10'd0;
            t_prev_q  <= 10'd0;
            pen_chk_q <= 1'b0;
        end else begin
            pen_chk_q <= frame_start;
            if (frame_start) begin
                t_cur_q  <= pixel_timer;
                t_prev_q <= t_cur_q;
            end
        end
    end

    assign penalty = pen_chk_q && (state_q == ST_RUN) && (t_cur_q < t_prev_q);

    // Flash counter: per-frame saturating decrement; the penalty load lands
    // one cycle after that frame's decrement and so wins; a restart clears.
    always_comb begin
        flash_d = flash_q;
        if (frame_start && (flash_q != '0)) begin
            flash_d = flash_q - 1'b1;
        end
        if (penalty) begin
            flash_d = FLASH_LOAD;
        end
        if (start_trigger) begin
            flash_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_q <= '0;
        end else begin
            flash_q <= flash_d;
        end
    end

    // Blink frame / half-period counters.
    always_comb begin
        blink_frm_d = blink_frm_q;
        blink_tog_d = blink_tog_q;
        if (start_trigger || ((state_q == ST_RUN) && end_trigger)) begin
            blink_frm_d = '0;
            blink_tog_d = '0;
        end else if ((state_q == ST_BLINK) && frame_start) begin
            if (blink_frm_q == FRM_LAST) begin
                blink_frm_d = '0;
                blink_tog_d = blink_tog_q + 1'b1;
            end else begin
                blink_frm_d = blink_frm_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_frm_q <= '0;
            blink_tog_q <= '0;
        end else begin
            blink_frm_q <= blink_frm_d;
            blink_tog_q <= blink_tog_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; start_trigger overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (end_trigger) begin
                    state_d = ST_BLINK;
                end
            end
            ST_BLINK: begin
                if (frame_start && (blink_frm_q == FRM_LAST) && (blink_tog_q == TOG_LAST)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (start_trigger) begin
            state_d = ST_RUN;
        end
    end

    // FSM outputs: hide the whole bar on odd blink half-periods, and drop
    // the fill once the blink sequence has finished.
    always_comb begin
        bar_hide   = 1'b0;
        fill_allow = 1'b1;
        case (state_q)
            ST_BLINK: bar_hide   = blink_tog_q[0];
            ST_DONE:  fill_allow = 1'b0;
            default:  ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Stage 1: region, border and fill compares
    // -----------------------------------------------------------------------
    logic [9:0]  rem;
    logic [9:0]  fill_lim;
    logic        in_region;
    logic        on_border;
    logic        in_fill;

    always_comb begin
        rem       = (t_cur_q >= W_10) ? 10'd0 : (W_10 - t_cur_q);
        fill_lim  = X_FIRST + rem;
        in_region = (x_pixel >= X_FIRST) && (x_pixel < X_END) &&
                    (y_pixel >= Y_FIRST) && (y_pixel < Y_END);
        on_border = in_region &&
                    ((x_pixel == X_FIRST) || (x_pixel == X_LAST) ||
                     (y_pixel == Y_FIRST) || (y_pixel == Y_LAST));
        in_fill   = in_region && !on_border && fill_allow && (x_pixel < fill_lim);
    end

    logic        hit_p1_q;
    logic        border_p1_q;
    logic        fill_p1_q;
    logic        hide_p1_q;
    logic [11:0] fill_rgb_p1_q;
    logic [11:0] rgb_p1_q;
    logic        vld_p1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_p1_q      <= 1'b0;
            border_p1_q   <= 1'b0;
            fill_p1_q     <= 1'b0;
            hide_p1_q     <= 1'b0;
            fill_rgb_p1_q <= 12'h000;
            rgb_p1_q      <= 12'h000;
            vld_p1_q      <= 1'b0;
        end else begin
            hit_p1_q      <= in_region;
            border_p1_q   <= on_border;
            fill_p1_q     <= in_fill;
            hide_p1_q     <= bar_hide;
            fill_rgb_p1_q <= fill_colour(rem, flash_q != '0);
            rgb_p1_q      <= rgb_in;
            vld_p1_q      <= display_en;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: colour mux
    // -----------------------------------------------------------------------
    logic [11:0] pix_d;

    always_comb begin
        if (!vld_p1_q) begin
            pix_d = 12'h000;
        end else if (!hit_p1_q || hide_p1_q) begin
            pix_d = rgb_p1_q;
        end else if (border_p1_q) begin
            pix_d = COL_WHITE;
        end else if (fill_p1_q) begin
            pix_d = fill_rgb_p1_q;
        end else begin
            pix_d = COL_EMPTY;
        end
    end

    logic [11:0] rgb_p2_q;
    logic        hit_p2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_p2_q <= 12'h000;
            hit_p2_q <= 1'b0;
        end else begin
            rgb_p2_q <= pix_d;
            hit_p2_q <= hit_p1_q;
        end
    end

    assign rgb_out = rgb_p2_q;
    assign bar_hit = hit_p2_q;

endmodule

// File: doc/timer_bar_renderer.md
# timer_bar_renderer

Downstream VGA stage for the game timer. Consumes the 10-bit elapsed-time value (`pixel_timer`, 0..199) and the one-cycle `end_trigger` pulse. Overlays a horizontal countdown bar onto the pixel stream coming from the VGA scan generator. Adds frame-synchronous sampling (no tearing), a white flash when a time penalty makes the bar jump, and a blink sequence after time runs out.

## Interface
Parameters:
- `BAR_X0`, 220, left x of the bar frame
- `BAR_Y0`, 20, top y of the bar frame
- `BAR_W`, 200, bar width in pixels; equals the full timer range
- `BAR_H`, 16, bar height in pixels
- `FLASH_FRAMES`, 15, frames of white flash after a penalty
- `BLINK_FRAMES`, 30, frames per blink half-period
- `BLINK_TOGGLES`, 6, half-periods in the end-of-game blink

Ports:
- `clk` in 1: pixel-domain clock.
- `reset` in 1: synchronous, active-high.
- `x_pixel` in 10: current scan x.
- `y_pixel` in 10: current scan y.
- `display_en` in 1: active video.
- `frame_start` in 1: one-cycle pulse at the first cycle of each frame.
- `pixel_timer` in 10: elapsed time from the game timer.
- `start_trigger` in 1: game start pulse, the same signal that drives the timer.
- `end_trigger` in 1: timeout pulse.
- `rgb_in` in 12: background pixel, 4:4:4.
- `rgb_out` out 12: composited pixel.
- `bar_hit` out 1: pixel lies inside the bar frame, aligned with `rgb_out`.

## Operation
- **Frame latch.** On `frame_start`, `t_cur <= pixel_timer` and `t_prev <= t_cur`. Drawing uses only `t_cur`.
- **Remaining width.** `rem = (t_cur >= BAR_W) ? 0 : BAR_W - t_cur`, computed in 10 bits.
- **Frame region.** `BAR_X0 <= x < BAR_X0+BAR_W` and `BAR_Y0 <= y < BAR_Y0+BAR_H`.
  - Border: 1 px ring on the outer edge of the region, colour 12'hFFF.
  - Fill: interior pixels with `x < BAR_X0+rem`.
  - Empty interior: 12'h222.
- **Fill colour.**
  - `rem > 100`: 12'h0F0.
  - `40 <= rem <= 100`: 12'hFF0.
  - `rem < 40`: 12'hF00.
  - While `flash_cnt != 0`, fill is 12'hFFF.
- **Penalty.** Detected on the cycle after `frame_start` when `t_cur < t_prev` in state RUN. It loads `flash_cnt = FLASH_FRAMES`. `flash_cnt` decrements on each `frame_start` and saturates at 0. A new penalty reloads it.
- **Outside the frame region**, `rgb_out = rgb_in`.
- **Blanking.** `rgb_out = 0` whenever delayed `display_en` = 0.
- **State machine** (state is RUN after reset):
  - RUN: normal drawing. `end_trigger` -> BLINK, with `blink_frm = 0` and `blink_tog = 0`.
  - BLINK: counts frames in `blink_frm`. When `blink_frm == BLINK_FRAMES-1` on a `frame_start`, it clears `blink_frm` and increments `blink_tog`. Fill and border are suppressed while `blink_tog` is odd, so `rgb_in` shows through. After toggle `BLINK_TOGGLES-1` completes -> DONE.
  - DONE: border drawn, interior all 12'h222 (no fill). `start_trigger` -> RUN and clears `flash_cnt`.
  - `start_trigger` in any state -> RUN. It takes priority over a simultaneous `end_trigger`.
  - `end_trigger` in BLINK or DONE is ignored.
- No penalty detection in BLINK or DONE.

## Timing
- **Latency.** Pixel path is 2 cycles, from `x_pixel`/`y_pixel`/`display_en`/`rgb_in` to `rgb_out`/`bar_hit`.
  - Stage 1 registers the region, border and fill compare results plus `rgb_in` and `display_en`.
  - Stage 2 registers the colour mux.
- **Reset values.**
  - `rgb_out` = 0, `bar_hit` = 0.
  - `t_cur` = `t_prev` = 0, so the bar is full.
  - `flash_cnt` = 0; state RUN; blink counters 0.
- **Reset mid-frame.** Outputs are 0 for 2 cycles, then follow the pipeline. The bar is full until the next `frame_start`.
- **Mid-frame changes.** A `pixel_timer` change never alters the current frame; it is visible from the next `frame_start`.
- **Pulse capture.** `end_trigger` and `start_trigger` are single-cycle pulses and are captured on any cycle, not only at frame edges.
- **Region bounds.** Comparisons are unsigned 10-bit. Right and bottom bounds are exclusive.

## Test plan
- **Reset and idle bar.** Reset, then one frame with `pixel_timer`=0.
  - Pixel (220,20) -> 12'hFFF (border).
  - (300,28) -> 12'h0F0.
  - (100,100) -> `rgb_in`.
  - Output appears 2 cycles after input.
- **Shrink and colour thresholds.**
  - `pixel_timer`=120 (rem 80): (299,28) -> 12'hFF0 and (301,28) -> 12'h222.
  - `pixel_timer`=170 (rem 30): fill 12'hF00.
  - `pixel_timer`=205: no fill (clamp).
- **Tearing guard.** Change `pixel_timer` 50->60 mid-frame -> the current frame still uses rem 150; the next frame uses rem 140.
- **Penalty flash.** Frame N `t`=100, frame N+1 `t`=80 -> fill 12'hFFF for 15 frames, then green.
  - A second drop during the flash restarts the 15-frame count.
- **Timeout blink.** Pulse `end_trigger` -> the bar alternates visible/hidden every 30 frames, 6 half-periods, then DONE shows border with 12'h222 interior.
  - A second `end_trigger` in BLINK has no effect.
- **Restart priority.** `start_trigger` and `end_trigger` in the same cycle during RUN -> stays RUN.
  - `start_trigger` in DONE -> RUN, with the fill restored on the next frame.
